// File: rtl/mux_8_1_sched.sv
`default_nettype none
// ============================================================================
// Module   : mux_8_1_sched
// Brief    : Round-robin scheduler driving the select of a shared 8:1 mux.
//            Grants are registered and one-hot, end on owner release or on
//            a hold-limit timeout, and are separated by one dead (GAP) cycle
//            so the mux select never changes under an asserted grant.
// Options  : MUX_8_1_SCHED_PRIO_EN - when defined, requester 0 always wins
//            arbitration; requesters 1-7 share round-robin among themselves.
// Revision : 1.0 - initial release
// ============================================================================
module mux_8_1_sched #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [2:0] s,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       expired
);

  // Last cycle index of a grant; reaching it while still requested ends the grant.
  localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_s;
  logic [7:0] r_gnt;
  logic       r_busy;
  logic       r_expired;
  logic [2:0] r_last;
  logic [7:0] r_hold_cnt;

  logic [2:0] w_win;
  logic       w_found;
  logic [2:0] w_cand;

  assign s       = r_s;
  assign gnt     = r_gnt;
  assign busy    = r_busy;
  assign expired = r_expired;

  // Pick the winner: first set request at or after last+1, wrapping upward.
  // The final candidate (offset 8) is the previous owner itself, so a timed-out
  // owner is re-granted only when nobody else is requesting.
  always_comb begin
    w_win   = 3'd0;
    w_found = 1'b0;
    w_cand  = 3'd0;
`ifdef MUX_8_1_SCHED_PRIO_EN
    // Index 0 overrides the rotation; with req[0] low the loop below can never
    // select 0, which leaves 1-7 rotating among themselves.
    if (req[0]) begin
      w_win   = 3'd0;
      w_found = 1'b1;
    end
`endif
    for (int i = 1; i <= 8; i++) begin
      w_cand = r_last + 3'(i);
      if (!w_found && req[w_cand]) begin
        w_win   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  // Scheduler state machine; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_s        <= 3'd0;
      r_gnt      <= 8'd0;
      r_busy     <= 1'b0;
      r_expired  <= 1'b0;
      r_last     <= 3'd7;
      r_hold_cnt <= 8'd0;
    end else begin
      r_expired <= 1'b0;
      case (r_state)
        ST_IDLE, ST_GAP: begin
          if (w_found) begin
            r_state    <= ST_GRANT;
            r_gnt      <= 8'b1 << w_win;
            r_s        <= w_win;
            r_last     <= w_win;
            r_hold_cnt <= 8'd0;
            r_busy     <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_gnt   <= 8'd0;
            r_busy  <= 1'b0;
          end
        end
        ST_GRANT: begin
          r_hold_cnt <= r_hold_cnt + 8'd1;
          if (!req[r_s]) begin
            // Owner released: no timeout pulse even if the limit was also hit.
            r_state <= ST_GAP;
            r_gnt   <= 8'd0;
            r_busy  <= 1'b0;
          end else if (r_hold_cnt == c_HOLD_LAST) begin
            r_state   <= ST_GAP;
            r_gnt     <= 8'd0;
            r_busy    <= 1'b0;
            r_expired <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 8'd0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_8_1_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_8_1_sched
// Brief    : Directed self-checking bench for mux_8_1_sched. One instance
//            with HOLD_CYCLES=2 (round-robin sweep) and one with
//            HOLD_CYCLES=4 (reset, hold limit, release, mid-grant reset,
//            index-0 priority behaviour).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_8_1_sched;

  logic       clk;
  logic       reset2, reset4;
  logic [7:0] req2, req4;
  logic [2:0] s2, s4;
  logic [7:0] gnt2, gnt4;
  logic       busy2, busy4;
  logic       exp2, exp4;

  int n_vec;
  int n_err;

  mux_8_1_sched #(.HOLD_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(reset2), .req(req2),
    .s(s2), .gnt(gnt2), .busy(busy2), .expired(exp2)
  );

  mux_8_1_sched #(.HOLD_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset4), .req(req4),
    .s(s4), .gnt(gnt4), .busy(busy4), .expired(exp4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check4(input string tag, input logic [7:0] eg, input logic [2:0] es,
                        input logic eb, input logic ee);
    check({tag, ".gnt"}, gnt4, eg);
    check({tag, ".s"}, {5'd0, s4}, {5'd0, es});
    check({tag, ".busy"}, {7'd0, busy4}, {7'd0, eb});
    check({tag, ".expired"}, {7'd0, exp4}, {7'd0, ee});
  endtask

  logic [7:0] prio_exp [3];

  initial begin
    n_vec  = 0;
    n_err  = 0;
    reset2 = 1'b1;
    reset4 = 1'b1;
    req2   = 8'h00;
    req4   = 8'hFF;
`ifdef MUX_8_1_SCHED_PRIO_EN
    prio_exp[0] = 8'h01; prio_exp[1] = 8'h01; prio_exp[2] = 8'h01;
`else
    prio_exp[0] = 8'h01; prio_exp[1] = 8'h80; prio_exp[2] = 8'h01;
`endif
    tick();
    tick();

    // ---- Round-robin sweep, HOLD_CYCLES=2, req=FF ----
    check("rr_reset.gnt", gnt2, 8'h00);
    reset2 = 1'b0;
    req2   = 8'hFF;
    for (int k = 0; k <= 8; k++) begin
      tick();
      check($sformatf("rr%0d.c1.gnt", k), gnt2, 8'h01 << (k % 8));
      check($sformatf("rr%0d.c1.s", k), {5'd0, s2}, 8'(k % 8));
      tick();
      check($sformatf("rr%0d.c2.gnt", k), gnt2, 8'h01 << (k % 8));
      tick();
      check($sformatf("rr%0d.gap.gnt", k), gnt2, 8'h00);
      check($sformatf("rr%0d.gap.s", k), {5'd0, s2}, 8'(k % 8));
      check($sformatf("rr%0d.gap.exp", k), {7'd0, exp2}, 8'h01);
    end
    req2 = 8'h00;

    // ---- Reset held with req=FF ----
    tick();
    check4("rst_a", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    check4("rst_b", 8'h00, 3'd0, 1'b0, 1'b0);
    reset4 = 1'b0;
    tick();
    check4("first_gnt", 8'h01, 3'd0, 1'b1, 1'b0);
    req4 = 8'h00;
    tick();
    check4("first_rel", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();

    // ---- Hold limit, req=08 ----
    req4 = 8'h08;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check4($sformatf("hold_c%0d", c), 8'h08, 3'd3, 1'b1, 1'b0);
    end
    tick();
    check4("hold_gap", 8'h00, 3'd3, 1'b0, 1'b1);
    tick();
    check4("hold_regnt", 8'h08, 3'd3, 1'b1, 1'b0);
    req4 = 8'h00;
    tick();
    check4("hold_rel", 8'h00, 3'd3, 1'b0, 1'b0);
    tick();

    // ---- Early release: owner 2, then 5 waiting ----
    req4 = 8'h04;
    tick();
    check4("er_c1", 8'h04, 3'd2, 1'b1, 1'b0);
    req4 = 8'h24;
    tick();
    check4("er_c2", 8'h04, 3'd2, 1'b1, 1'b0);
    req4 = 8'h20;
    tick();
    check4("er_gap", 8'h00, 3'd2, 1'b0, 1'b0);
    tick();
    check4("er_next", 8'h20, 3'd5, 1'b1, 1'b0);
    req4 = 8'h00;
    tick();
    tick();

    // ---- Reset during 2nd cycle of a grant to 6 ----
    req4 = 8'h40;
    tick();
    check4("mr_c1", 8'h40, 3'd6, 1'b1, 1'b0);
    tick();
    check4("mr_c2", 8'h40, 3'd6, 1'b1, 1'b0);
    reset4 = 1'b1;
    tick();
    check4("mr_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    req4   = 8'h00;
    reset4 = 1'b0;
    tick();
    check4("mr_after", 8'h00, 3'd0, 1'b0, 1'b0);

    // ---- req=81 steady from reset state (last=7) ----
    req4 = 8'h81;
    for (int g = 0; g < 3; g++) begin
      tick();
      check($sformatf("pr%0d.gnt", g), gnt4, prio_exp[g]);
      tick();
      tick();
      tick();
      check($sformatf("pr%0d.c4.gnt", g), gnt4, prio_exp[g]);
      tick();
      check($sformatf("pr%0d.gap.gnt", g), gnt4, 8'h00);
      check($sformatf("pr%0d.gap.exp", g), {7'd0, exp4}, 8'h01);
    end
    req4 = 8'h00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
